// File: rtl/fft_pkg.sv
// Shared FFT definitions: default sizes, complex bin type, fill-state encoding
// and the bit-reversal index helper used by the FFT core and its unloader.
package fft_pkg;

  localparam int FFT_DATA_WIDTH = 16;
  localparam int FFT_N          = 16;

  typedef struct packed {
    logic signed [FFT_DATA_WIDTH-1:0] re;
    logic signed [FFT_DATA_WIDTH-1:0] im;
  } complex_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } fill_state_e;

  // Reverses the low log2n bits of idx; supports frames up to 256 points.
  function automatic logic [7:0] bitrev(input logic [7:0] idx, input int unsigned log2n);
    logic [7:0] r;
    r = '0;
    for (int unsigned b = 0; b < 8; b++) begin
      if (b < log2n) r[log2n-1-b] = idx[b];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft16_bitrev_unloader_if.sv
// Frame input / bin stream output bundle of the FFT unloader.
interface fft16_bitrev_unloader_if
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = FFT_DATA_WIDTH,
  parameter int N          = FFT_N,
  parameter int DROP_CNT_W = 8
);
  localparam int LOG2N = $clog2(N);

  logic                         in_valid;
  logic                         in_ready;
  logic [N-1:0][DATA_WIDTH-1:0] in_re;
  logic [N-1:0][DATA_WIDTH-1:0] in_im;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [DATA_WIDTH-1:0] out_re;
  logic signed [DATA_WIDTH-1:0] out_im;
  logic [LOG2N-1:0]             out_idx;
  logic                         out_last;
  logic                         drop_pulse;
  logic [DROP_CNT_W-1:0]        drop_cnt;

  modport master (
    output in_valid, in_re, in_im, out_ready,
    input  in_ready, out_valid, out_re, out_im, out_idx, out_last, drop_pulse, drop_cnt
  );

  modport slave (
    input  in_valid, in_re, in_im, out_ready,
    output in_ready, out_valid, out_re, out_im, out_idx, out_last, drop_pulse, drop_cnt
  );

endinterface

// File: rtl/fft_frame_bank.sv
// One frame of complex bins: full-frame parallel write, single indexed read.
module fft_frame_bank
  import fft_pkg::*;
#(
  parameter int  N = FFT_N,
  parameter type T = complex_t
) (
  input  logic                 clk,
  input  logic                 i_we,
  input  T [N-1:0]             i_frame,
  input  logic [$clog2(N)-1:0] i_raddr,
  output T                     o_rdata
);

  T r_mem [N];

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int unsigned k = 0; k < N; k++) r_mem[k] <= i_frame[k];
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fft16_bitrev_unloader.sv
// Double-buffered FFT output stage: captures a bit-reversed parallel frame and
// streams it in natural order with valid/ready; frames arriving while full are dropped.
module fft16_bitrev_unloader
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = FFT_DATA_WIDTH,
  parameter int N          = FFT_N,
  parameter int DROP_CNT_W = 8
) (
  input logic                    clk,
  input logic                    rst,
  fft16_bitrev_unloader_if.slave bus
);

  localparam int LOG2N = $clog2(N);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] re;
    logic [DATA_WIDTH-1:0] im;
  } bin_t;

  fill_state_e           r_state, w_state_nxt;
  logic                  r_wr_bank, r_rd_bank;
  logic [LOG2N-1:0]      r_rd_idx;
  logic [DROP_CNT_W-1:0] r_drop_cnt;

  logic                  w_in_ready, w_accept, w_out_valid, w_xfer, w_last_xfer, w_drop;
  logic [LOG2N-1:0]      w_rd_addr;
  bin_t [N-1:0]          w_frame;
  bin_t                  w_rdata0, w_rdata1, w_rdata;

  // in_ready is held low while rst is asserted, so no accept or drop can occur then.
  assign w_in_ready  = !rst && (r_state != FULL);
  assign w_accept    = bus.in_valid && w_in_ready;
  assign w_drop      = bus.in_valid && !rst && (r_state == FULL);
  assign w_out_valid = (r_state != EMPTY);
  assign w_xfer      = w_out_valid && bus.out_ready;
  assign w_last_xfer = w_xfer && (r_rd_idx == LOG2N'(N-1));
  assign w_rd_addr   = LOG2N'(bitrev(8'(r_rd_idx), LOG2N));

  always_comb begin
    w_frame = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_frame[k].re = bus.in_re[k];
      w_frame[k].im = bus.in_im[k];
    end
  end

  fft_frame_bank #(.N(N), .T(bin_t)) u_bank0 (
    .clk     (clk),
    .i_we    (w_accept && !r_wr_bank),
    .i_frame (w_frame),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rdata0)
  );

  fft_frame_bank #(.N(N), .T(bin_t)) u_bank1 (
    .clk     (clk),
    .i_we    (w_accept && r_wr_bank),
    .i_frame (w_frame),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rdata1)
  );

  assign w_rdata = r_rd_bank ? w_rdata1 : w_rdata0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= EMPTY;
    else     r_state <= w_state_nxt;
  end

  // Accept and final read in the same cycle cancel out, leaving the fill level unchanged.
  always_comb begin
    w_state_nxt = r_state;
    if (w_accept && !w_last_xfer) begin
      w_state_nxt = (r_state == EMPTY) ? ONE : FULL;
    end else if (!w_accept && w_last_xfer) begin
      w_state_nxt = (r_state == FULL) ? ONE : EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_bank  <= 1'b0;
      r_rd_bank  <= 1'b0;
      r_rd_idx   <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_accept) r_wr_bank <= !r_wr_bank;
      if (w_xfer) begin
        if (w_last_xfer) begin
          r_rd_idx  <= '0;
          r_rd_bank <= !r_rd_bank;
        end else begin
          r_rd_idx <= r_rd_idx + 1'b1;
        end
      end
      if (w_drop && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  // Bank contents are unreset, so read data is forced to zero while nothing is stored.
  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = w_out_valid;
  assign bus.out_re     = w_out_valid ? w_rdata.re : '0;
  assign bus.out_im     = w_out_valid ? w_rdata.im : '0;
  assign bus.out_idx    = r_rd_idx;
  assign bus.out_last   = w_out_valid && (r_rd_idx == LOG2N'(N-1));
  assign bus.drop_pulse = w_drop;
  assign bus.drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_fft16_bitrev_unloader.sv
// Scoreboard bench for fft16_bitrev_unloader: stimulus queues expected bins,
// a negedge monitor compares every output transfer.
module tb_fft16_bitrev_unloader;

  localparam int DW  = 16;
  localparam int NN  = 16;
  localparam int DCW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fft16_bitrev_unloader_if #(.DATA_WIDTH(DW), .N(NN), .DROP_CNT_W(DCW)) bus ();

  fft16_bitrev_unloader #(.DATA_WIDTH(DW), .N(NN), .DROP_CNT_W(DCW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [15:0] re;
    logic [15:0] im;
    logic [3:0]  idx;
    logic        last;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks     = 0;
  int   n_fail       = 0;
  int   valid_cycles = 0;
  int   drops_seen   = 0;
  int   br[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame tag t: in_re[k] = t*256+k, in_im[k] = -(t*256+k); bin j of the output is slot br[j].
  task automatic present(input int tag, input bit exp_acc);
    bus.in_valid = 1'b1;
    for (int k = 0; k < NN; k++) begin
      bus.in_re[k] = 16'(tag * 256 + k);
      bus.in_im[k] = 16'(-(tag * 256 + k));
    end
    @(negedge clk);
    check("in_ready", 32'(bus.in_ready), 32'(exp_acc));
    check("drop_pulse", 32'(bus.drop_pulse), 32'(!exp_acc));
    if (exp_acc) begin
      for (int j = 0; j < NN; j++) begin
        sb.push_back('{re: 16'(tag * 256 + br[j]), im: 16'(-(tag * 256 + br[j])),
                       idx: 4'(j), last: (j == NN - 1)});
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400 && (sb.size() != 0 || bus.out_valid); i++) begin
      @(posedge clk);
      #1;
    end
    check("drain_left", 32'(sb.size()), 32'd0);
  endtask

  task automatic wait_idx(input int idx);
    for (int i = 0; i < 40 && !(bus.out_valid && bus.out_idx == 4'(idx)); i++) begin
      @(posedge clk);
      #1;
    end
    check("reach_idx", 32'(bus.out_idx), 32'(idx));
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_valid) valid_cycles++;
      if (bus.drop_pulse) drops_seen++;
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_out: got idx %0d re %0h, expected no transfer",
                   bus.out_idx, bus.out_re);
        end else begin
          mon_e = sb.pop_front();
          check("out_idx", 32'(bus.out_idx), 32'(mon_e.idx));
          check("out_re", 32'($unsigned(bus.out_re)), 32'(mon_e.re));
          check("out_im", 32'($unsigned(bus.out_im)), 32'(mon_e.im));
          check("out_last", 32'(bus.out_last), 32'(mon_e.last));
        end
      end
    end
  end

  initial begin
    int vc0, dr0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_re     = '0;
    bus.in_im     = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_drop_cnt", 32'(bus.drop_cnt), 32'd0);
    check("rst_out_re", 32'($unsigned(bus.out_re)), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;

    // Reorder: tag 0 gives in_re[k]=k, in_im[k]=-k
    bus.out_ready = 1'b1;
    present(0, 1'b1);
    check("first_idx", 32'(bus.out_idx), 32'd0);
    check("first_valid", 32'(bus.out_valid), 32'd1);
    wait_drain();

    // Back-to-back: B accepted 16 cycles after A
    present(1, 1'b1);
    vc0 = valid_cycles;
    dr0 = drops_seen;
    repeat (15) begin
      @(posedge clk);
      #1;
    end
    present(2, 1'b1);
    repeat (16) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    #1;
    check("b2b_valid_cycles", 32'(valid_cycles - vc0), 32'd32);
    check("b2b_valid_after", 32'(bus.out_valid), 32'd0);
    check("b2b_no_drop", 32'(drops_seen - dr0), 32'd0);
    @(posedge clk);
    #1;
    wait_drain();

    // Backpressure: fill both banks, third frame dropped
    bus.out_ready = 1'b0;
    present(3, 1'b1);
    present(4, 1'b1);
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    present(5, 1'b0);
    check("drop_cnt_1", 32'(bus.drop_cnt), 32'd1);
    bus.out_ready = 1'b1;
    wait_drain();

    // Stall mid-frame at bin 5 for 7 cycles
    present(6, 1'b1);
    wait_idx(5);
    bus.out_ready = 1'b0;
    repeat (7) begin
      @(negedge clk);
      check("stall_valid", 32'(bus.out_valid), 32'd1);
      check("stall_idx", 32'(bus.out_idx), 32'd5);
      check("stall_re", 32'($unsigned(bus.out_re)), 32'(6 * 256 + 10));
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    wait_drain();

    // Edge on full: in_valid coincides with final read of A
    bus.out_ready = 1'b0;
    present(7, 1'b1);
    present(8, 1'b1);
    bus.out_ready = 1'b1;
    wait_idx(15);
    present(9, 1'b0);
    present(10, 1'b1);
    check("edge_drop_cnt", 32'(bus.drop_cnt), 32'd2);
    @(negedge clk);
    check("edge_refull", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    wait_drain();

    // Saturation, then reset mid-frame
    bus.out_ready = 1'b0;
    present(11, 1'b1);
    present(12, 1'b1);
    for (int i = 0; i < 300; i++) present(13, 1'b0);
    check("drop_cnt_sat", 32'(bus.drop_cnt), 32'd255);
    bus.out_ready = 1'b1;
    wait_idx(9);
    rst = 1'b1;
    #1;
    sb.delete();
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_in_ready", 32'(bus.in_ready), 32'd0);
    check("arst_out_last", 32'(bus.out_last), 32'd0);
    check("arst_drop_pulse", 32'(bus.drop_pulse), 32'd0);
    check("arst_drop_cnt", 32'(bus.drop_cnt), 32'd0);
    check("arst_out_re", 32'($unsigned(bus.out_re)), 32'd0);
    check("arst_out_im", 32'($unsigned(bus.out_im)), 32'd0);
    check("arst_out_idx", 32'(bus.out_idx), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_in_ready", 32'(bus.in_ready), 32'd1);
    check("rel_out_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    present(14, 1'b1);
    check("post_rst_first_idx", 32'(bus.out_idx), 32'd0);
    wait_drain();

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
